// File: rtl/imem_loader_if.sv
// Byte-stream source handshake plus instruction-memory write port for imem_loader.
// The master drives the byte stream and observes writes; the slave is the loader.
interface imem_loader_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 24
);
    logic               byte_valid;
    logic [7:0]         byte_data;
    logic               byte_ready;
    logic               im_wr_en;
    logic [ADDR_W-1:0]  im_wr_addr;
    logic [INSTR_W-1:0] im_wr_data;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, im_wr_en, im_wr_addr, im_wr_data
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, im_wr_en, im_wr_addr, im_wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: length-prefixed byte stream -> 24-bit words at addr 0..N-1.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 24,
    parameter int DEPTH   = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          core_reset,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_PAYLOAD,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    // State entered once the payload (or an empty image) is complete.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_FINAL = S_CHECK;
`else
    localparam state_t S_FINAL = S_DONE;
`endif

    state_t             state_q, state_d;
    logic [7:0]         len_hi_q;
    logic [15:0]        n_q;
    logic [1:0]         byte_cnt_q;
    logic [ADDR_W-1:0]  word_idx_q;
    logic [15:0]        hold_q;
    logic [15:0]        len_full;
    logic               oversize;
    logic               last_word;
    logic               accept;
    logic               restart;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         csum_q;
`endif

    assign len_full  = {len_hi_q, bus.byte_data};
    assign oversize  = 32'(len_full) > 32'(DEPTH);
    assign last_word = (word_idx_q == ADDR_W'(n_q - 16'd1));
    assign accept    = bus.byte_valid && bus.byte_ready;
    assign restart   = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        bus.byte_ready = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        err            = 1'b0;
        core_reset     = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (bus.byte_valid) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (bus.byte_valid) begin
                    if (oversize)              state_d = S_ERR;
                    else if (len_full == '0)   state_d = S_FINAL;
                    else                       state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (bus.byte_valid && byte_cnt_q == 2'd2 && last_word) state_d = S_FINAL;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                bus.byte_ready = 1'b1;
                busy           = 1'b1;
                if (bus.byte_valid) state_d = (bus.byte_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            S_DONE: begin
                done       = 1'b1;
                core_reset = 1'b0;
                if (start) state_d = S_LEN_HI;
            end
            S_ERR: begin
                err = 1'b1;
                if (start) state_d = S_LEN_HI;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Word assembly: first two bytes park in hold_q, the third completes the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_hi_q       <= '0;
            n_q            <= '0;
            byte_cnt_q     <= '0;
            word_idx_q     <= '0;
            hold_q         <= '0;
            bus.im_wr_en   <= 1'b0;
            bus.im_wr_addr <= '0;
            bus.im_wr_data <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q         <= '0;
`endif
        end else begin
            bus.im_wr_en <= 1'b0;
            if (restart) begin
                byte_cnt_q <= '0;
                word_idx_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum_q     <= '0;
`endif
            end else if (accept) begin
                case (state_q)
                    S_LEN_HI: len_hi_q <= bus.byte_data;
                    S_LEN_LO: n_q      <= len_full;
                    S_PAYLOAD: begin
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ bus.byte_data;
`endif
                        if (byte_cnt_q == 2'd2) begin
                            byte_cnt_q     <= '0;
                            bus.im_wr_en   <= 1'b1;
                            bus.im_wr_addr <= word_idx_q;
                            bus.im_wr_data <= INSTR_W'({hold_q, bus.byte_data});
                            word_idx_q     <= word_idx_q + 1'b1;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            hold_q     <= {hold_q[7:0], bus.byte_data};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a stream-level reference model.
// Honours LOADER_CHECKSUM_EN the same way the design does.
module tb_imem_loader;
    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 24;
    localparam int DEPTH   = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic core_reset, busy, done, err;

    imem_loader_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bus.slave),
        .core_reset (core_reset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every write pulse seen on the memory port, as {addr, data}.
    logic [39:0] wr_log[$];
    always @(negedge clk) if (bus.im_wr_en === 1'b1) wr_log.push_back({bus.im_wr_addr, bus.im_wr_data});

    logic [7:0]  stim[$];
    logic [39:0] exp_wr[$];
    bit          exp_done;

    // Reference: interpret the stream directly -> expected writes and outcome.
    function automatic void model();
        int n;
        logic [7:0] x;
        exp_wr.delete();
        n = {stim[0], stim[1]};
        if (n > DEPTH) begin
            exp_done = 1'b0;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_wr.push_back({16'(i), stim[2+3*i], stim[3+3*i], stim[4+3*i]});
            x = x ^ stim[2+3*i] ^ stim[3+3*i] ^ stim[4+3*i];
        end
`ifdef LOADER_CHECKSUM_EN
        exp_done = (stim[2+3*n] == x);
`else
        exp_done = 1'b1;
`endif
    endfunction

    task automatic push_csum(input bit bad);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 2; i < stim.size(); i++) x = x ^ stim[i];
        if (bad) x = x ^ 8'(1 << $urandom_range(0, 7));
`ifdef LOADER_CHECKSUM_EN
        stim.push_back(x);
`endif
    endtask

    task automatic gen_stream(input int n, input bit bad);
        stim.delete();
        stim.push_back(n[15:8]);
        stim.push_back(n[7:0]);
        if (n > DEPTH) return;
        repeat (3 * n) stim.push_back(8'($urandom));
        push_csum(bad);
    endtask

    // Called just after a negedge; returns just after the negedge following the accept edge.
    task automatic send_byte(input string tag, input logic [7:0] b);
        int t;
        t = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (bus.byte_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (bus.byte_ready !== 1'b1) begin
            check({tag, "/ready_timeout"}, 32'(bus.byte_ready), 32'd1);
            bus.byte_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic run_load(input string name, input bit gaps);
        int base;
        model();
        base  = wr_log.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "/busy_after_start"}, 32'(busy), 32'd1);
        foreach (stim[i]) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    start = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                start = 1'b0;
            end
            send_byte(name, stim[i]);
        end
        check({name, "/done"},       32'(done),           32'(exp_done));
        check({name, "/err"},        32'(err),            32'(!exp_done));
        check({name, "/core_reset"}, 32'(core_reset),     32'(!exp_done));
        check({name, "/busy_end"},   32'(busy),           32'd0);
        check({name, "/ready_end"},  32'(bus.byte_ready), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        check({name, "/wr_en_end"},  32'(bus.im_wr_en),   32'd0);
`else
        check({name, "/wr_en_end"},  32'(bus.im_wr_en),   32'(exp_wr.size() > 0));
`endif
        repeat (3) @(negedge clk);
        check({name, "/n_writes"}, 32'(wr_log.size() - base), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && base + i < wr_log.size(); i++) begin
            check({name, "/wr_addr"}, 32'(wr_log[base+i][39:24]), 32'(exp_wr[i][39:24]));
            check({name, "/wr_data"}, 32'(wr_log[base+i][23:0]),  32'(exp_wr[i][23:0]));
        end
        check({name, "/done_level"}, 32'(done), 32'(exp_done));
    endtask

    task automatic basic_stream();
        stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
        push_csum(1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst/core_reset", 32'(core_reset),     32'd1);
        check("rst/busy",       32'(busy),           32'd0);
        check("rst/done",       32'(done),           32'd0);
        check("rst/err",        32'(err),            32'd0);
        check("rst/ready",      32'(bus.byte_ready), 32'd0);
        check("rst/wr_en",      32'(bus.im_wr_en),   32'd0);
        check("rst/wr_addr",    32'(bus.im_wr_addr), 32'd0);
        check("rst/wr_data",    32'(bus.im_wr_data), 32'd0);
        start = 1'b1;
        @(negedge clk);
        check("rst_vs_start/busy", 32'(busy), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);

        basic_stream();
        run_load("basic", 1'b0);

`ifdef LOADER_CHECKSUM_EN
        stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'h00};
        run_load("bad_csum", 1'b0);
`endif

        stim = '{8'h01, 8'h01};
        run_load("oversize", 1'b0);

        stim = '{8'h00, 8'h00};
        push_csum(1'b0);
        run_load("zero", 1'b0);

        basic_stream();
        run_load("stalled", 1'b1);

        // Reset after two payload bytes of word 1.
        basic_stream();
        base  = wr_log.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 7; i++) send_byte("midrst", stim[i]);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst/busy",       32'(busy),           32'd0);
        check("midrst/core_reset", 32'(core_reset),     32'd1);
        check("midrst/ready",      32'(bus.byte_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("midrst/n_writes", 32'(wr_log.size() - base), 32'd1);
        if (wr_log.size() > base)
            check("midrst/wr0", 32'(wr_log[base][39:0] & 40'hFF_FFFF_FFFF), 32'h0012_3456);
        run_load("after_rst", 1'b0);

        gen_stream(DEPTH, 1'b0);
        run_load("max_depth", 1'b0);

        for (int k = 0; k < 10; k++) begin
            int n;
            n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH + 1, 1000)) : int'($urandom_range(0, 6));
            gen_stream(n, $urandom_range(0, 3) == 0);
            run_load("random", 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
